// File: rtl/bin_gray_5bit_ser_enc_pkg.sv
// Shared definitions for the serial binary-to-Gray encoder: FSM state
// encoding, default word width and the counter sizing helper.
package bin_gray_5bit_ser_enc_pkg;

   // Two-state frame controller: waiting for a word, or shifting one out.
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   // Default word width of the 5-bit converter datapath.
   localparam int DEFAULT_WIDTH = 5;

   // Bit counters must be able to hold the value WIDTH itself, because the
   // counter advances once more on the final shift of a frame.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/bin_gray_bit_enc.sv
// One-bit serial binary-to-Gray encoder cell. Each Gray bit is the current
// binary bit XORed with the binary bit that preceded it (MSB-first), so the
// cell only has to remember the previous binary bit.
module bin_gray_bit_enc
   import bin_gray_5bit_ser_enc_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   input  logic b,
   output logic g,
   output logic prev
);

   // The first bit of a frame must pass through unchanged, hence prev is
   // forced to 0 by clr at every frame start.
   assign g = b ^ prev;

   // Previous-bit register: cleared on reset or frame start, advanced per bit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev <= 1'b0;
      end else if (clr) begin
         prev <= 1'b0;
      end else if (en) begin
         prev <= b;
      end
   end

endmodule

// File: rtl/bin_gray_5bit_ser_enc.sv
// Serial binary-to-Gray encoder. A parallel binary word is captured on start,
// shifted MSB-first through a one-bit XOR encoder cell, emitted as a serial
// Gray stream with a per-bit valid, and reassembled into a parallel Gray word
// that is presented together with a one-cycle done pulse.
module bin_gray_5bit_ser_enc
   import bin_gray_5bit_ser_enc_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] bin_in,
   output logic             busy,
   output logic             ser_out,
   output logic             ser_valid,
   output logic [WIDTH-1:0] gray_out,
   output logic             done
);

   localparam int CW = cnt_width(WIDTH);

   if (WIDTH < 2) begin : g_width_check
      $error("bin_gray_5bit_ser_enc: WIDTH must be at least 2");
   end

   state_t           state;
   state_t           state_nxt;
   logic             load;
   logic             shift;
   logic             last;

   logic [WIDTH-1:0] bin_sr;
   // Only the low WIDTH-1 Gray bits need storing: the final bit is appended
   // combinationally when the finished word is written to gray_out.
   logic [WIDTH-2:0] gray_sr;
   logic [WIDTH-1:0] gray_nxt;
   logic [CW-1:0]    cnt;
   logic             g;
   logic             prev;

   assign busy     = (state == ST_SHIFT);
   assign gray_nxt = {gray_sr, g};

   // Serial encoder cell fed by the MSB of the binary shift register.
   bin_gray_bit_enc u_bit_enc (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (load),
      .en   (shift),
      .b    (bin_sr[WIDTH-1]),
      .g    (g),
      .prev (prev)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and datapath strobes; start is only honoured in IDLE, which
   // also covers the done cycle so frames can run back to back.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      shift     = 1'b0;
      last      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            shift = 1'b1;
            if (cnt == CW'(WIDTH - 1)) begin
               last      = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Shift registers, bit counter and output registers. ser_valid and done
   // are single-cycle strobes; ser_out and gray_out hold between updates.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bin_sr    <= '0;
         gray_sr   <= '0;
         cnt       <= '0;
         ser_out   <= 1'b0;
         ser_valid <= 1'b0;
         gray_out  <= '0;
         done      <= 1'b0;
      end else begin
         ser_valid <= 1'b0;
         done      <= 1'b0;
         if (load) begin
            bin_sr  <= bin_in;
            gray_sr <= '0;
            cnt     <= '0;
         end else if (shift) begin
            ser_out   <= g;
            ser_valid <= 1'b1;
            bin_sr    <= bin_sr << 1;
            gray_sr   <= gray_nxt[WIDTH-2:0];
            cnt       <= cnt + CW'(1);
            if (last) begin
               gray_out <= gray_nxt;
               done     <= 1'b1;
            end
         end
      end
   end

   // The encoder cell must start every frame with a cleared history bit.
   a_prev_cleared: assert property (
      @(posedge clk) disable iff (!rst_n) (shift && cnt == '0) |-> !prev
   );

endmodule

// File: tb/tb_bin_gray_5bit_ser_enc.sv
// Self-checking bench for bin_gray_5bit_ser_enc. Stimulus pushes the expected
// Gray bits and word into queues when a start is accepted; the monitor pops
// them as the DUT produces serial bits and done pulses.
module tb_bin_gray_5bit_ser_enc;

   localparam int W = 5;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] bin_in;
   logic         busy;
   logic         ser_out;
   logic         ser_valid;
   logic [W-1:0] gray_out;
   logic         done;

   int n_checks = 0;
   int n_fail   = 0;

   bit           ser_q[$];
   logic [W-1:0] gray_q[$];

   // Reference model state (predicted outputs after the most recent edge).
   int           m_cnt     = 0;
   bit           m_started = 0;
   bit           m_sv      = 0;
   bit           m_done    = 0;
   bit           exp_ser   = 0;
   logic [W-1:0] exp_gray  = '0;
   logic [W-1:0] acc       = '0;
   int           cyc       = 0;
   int           last_done = 0;
   int           prev_done = 0;

   bin_gray_5bit_ser_enc #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .bin_in   (bin_in),
      .busy     (busy),
      .ser_out  (ser_out),
      .ser_valid(ser_valid),
      .gray_out (gray_out),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One frame followed by enough cycles to reach the done cycle plus one.
   task automatic frame(input logic [W-1:0] b);
      start  = 1'b1;
      bin_in = b;
      tick();
      start  = 1'b0;
      bin_in = ~b;
      repeat (W + 1) tick();
   endtask

   // Monitor and model: inputs are stable between posedge+1 and the next
   // posedge, so at the negedge they are exactly what the next edge samples.
   initial begin
      logic [W-1:0] gw;
      forever begin
         @(negedge clk);
         cyc++;
         if (m_started) begin
            if (m_sv) begin
               if (ser_q.size() == 0) check("ser_q_underflow", 1, 0);
               else exp_ser = ser_q.pop_front();
            end
            if (m_done) begin
               if (gray_q.size() == 0) check("gray_q_underflow", 1, 0);
               else exp_gray = gray_q.pop_front();
            end
            check("busy", busy, m_cnt != 0);
            check("ser_valid", ser_valid, m_sv);
            check("done", done, m_done);
            check("ser_out", ser_out, exp_ser);
            check("gray_out", gray_out, exp_gray);
            if (ser_valid === 1'b1) acc = {acc[W-2:0], ser_out};
            if (done === 1'b1) begin
               check("reassembled", acc, gray_out);
               prev_done = last_done;
               last_done = cyc;
            end
         end
         if (rst_n === 1'b0) begin
            m_started = 1;
            m_cnt     = 0;
            m_sv      = 0;
            m_done    = 0;
            exp_ser   = 0;
            exp_gray  = '0;
            ser_q.delete();
            gray_q.delete();
         end else if (m_started) begin
            m_sv   = (m_cnt != 0);
            m_done = (m_cnt == 1);
            if (m_cnt != 0) begin
               m_cnt--;
            end else if (start === 1'b1) begin
               gw = bin_in ^ (bin_in >> 1);
               for (int i = W - 1; i >= 0; i--) ser_q.push_back(gw[i]);
               gray_q.push_back(gw);
               m_cnt = W;
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n  = 1'b0;
      start  = 1'b0;
      bin_in = '0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();

      frame(5'b10110);
      frame(5'b11111);
      frame(5'b00000);

      // Back-to-back: second start lands in the done cycle of the first.
      start  = 1'b1;
      bin_in = 5'b01010;
      tick();
      start = 1'b0;
      repeat (W) tick();
      start  = 1'b1;
      bin_in = 5'b11111;
      tick();
      start = 1'b0;
      repeat (W + 1) tick();
      check("done_spacing", last_done - prev_done, W + 1);

      // start held through SHIFT with bin_in toggling.
      start = 1'b1;
      for (int i = 0; i < 14; i++) begin
         bin_in = W'($urandom_range(0, 31));
         tick();
      end
      start = 1'b0;
      repeat (W + 3) tick();

      // Reset asserted on the third shift edge of a frame.
      start  = 1'b1;
      bin_in = 5'b10110;
      tick();
      start = 1'b0;
      repeat (2) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      frame(5'b00001);

      // Exhaustive sweep of all input words.
      for (int b = 0; b < 32; b++) frame(W'(b));

      repeat (3) tick();
      check("ser_q_empty", ser_q.size(), 0);
      check("gray_q_empty", gray_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
